// File: rtl/ttt_turn_sequencer.sv
// rtl/ttt_turn_sequencer.sv - tic-tac-toe turn sequencer owning both players' board registers
// Alternates blue/red turns, validates and applies moves, times out idle players, judges win/draw.
module ttt_turn_sequencer #(
  parameter int TURN_TIMEOUT = 0,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move_valid,
  input  logic [1:0] move_row,
  input  logic [1:0] move_col,
  output logic       move_ack,
  output logic       move_err,
  output logic       timeout,
  output logic [1:0] turn,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [7:0] btemp1,
  output logic [7:0] btemp2,
  output logic [7:0] btemp3,
  output logic [7:0] redtemp1,
  output logic [7:0] redtemp2,
  output logic [7:0] redtemp3
);
  localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_BLUE, S_RED, S_CHECK, S_OVER} state_t;

  state_t        state;
  logic [8:0]    bcell;
  logic [8:0]    rcell;
  logic          mover;
  logic [CW-1:0] cnt;

  logic [3:0] idx;
  logic [8:0] mask;
  logic [8:0] mcell;
  logic       legal;
  logic       expired;
  logic       win;
  logic       full;

  // Cell (r,c) lives at bit 3r+c of the packed 9-cell boards.
  function automatic logic has_line(input logic [8:0] c);
    return (&c[2:0]) | (&c[5:3]) | (&c[8:6]) |
           (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]) |
           (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
  endfunction

  always_comb begin
    idx     = {2'b00, move_row} * 4'd3 + {2'b00, move_col};
    mask    = 9'd1 << idx;
    legal   = (move_row != 2'd3) && (move_col != 2'd3) && (((bcell | rcell) & mask) == 9'd0);
    expired = (TURN_TIMEOUT > 0) && (cnt == CNT_LAST);
    mcell   = mover ? rcell : bcell;
    win     = has_line(mcell);
    full    = &(bcell | rcell);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bcell     <= '0;
      rcell     <= '0;
      mover     <= 1'b0;
      cnt       <= '0;
      move_ack  <= 1'b0;
      move_err  <= 1'b0;
      timeout   <= 1'b0;
      turn      <= 2'b00;
      winner    <= 2'b00;
      game_over <= 1'b0;
    end else begin
      move_ack <= 1'b0;
      move_err <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            bcell     <= '0;
            rcell     <= '0;
            winner    <= 2'b00;
            game_over <= 1'b0;
            cnt       <= '0;
            state     <= FIRST_PLAYER ? S_RED : S_BLUE;
            turn      <= FIRST_PLAYER ? 2'b01 : 2'b10;
          end
        end
        S_BLUE, S_RED: begin
          cnt <= cnt + 1'b1;
          if (move_valid && legal) begin
            if (state == S_RED) rcell <= rcell | mask;
            else                bcell <= bcell | mask;
            mover    <= (state == S_RED);
            move_ack <= 1'b1;
            turn     <= 2'b00;
            state    <= S_CHECK;
          end else begin
            if (move_valid) move_err <= 1'b1;
            // A legal move on the expiry cycle takes priority over forfeiting the turn.
            if (expired) begin
              timeout <= 1'b1;
              cnt     <= '0;
              state   <= (state == S_RED) ? S_BLUE : S_RED;
              turn    <= (state == S_RED) ? 2'b10 : 2'b01;
            end
          end
        end
        S_CHECK: begin
          cnt <= '0;
          if (win) begin
            winner    <= mover ? 2'b01 : 2'b10;
            game_over <= 1'b1;
            state     <= S_OVER;
          end else if (full) begin
            winner    <= 2'b11;
            game_over <= 1'b1;
            state     <= S_OVER;
          end else begin
            state <= mover ? S_BLUE : S_RED;
            turn  <= mover ? 2'b10 : 2'b01;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Cell c of a row sits at bit 2c; odd bits are tied low.
  assign btemp1   = {3'b000, bcell[2], 1'b0, bcell[1], 1'b0, bcell[0]};
  assign btemp2   = {3'b000, bcell[5], 1'b0, bcell[4], 1'b0, bcell[3]};
  assign btemp3   = {3'b000, bcell[8], 1'b0, bcell[7], 1'b0, bcell[6]};
  assign redtemp1 = {3'b000, rcell[2], 1'b0, rcell[1], 1'b0, rcell[0]};
  assign redtemp2 = {3'b000, rcell[5], 1'b0, rcell[4], 1'b0, rcell[3]};
  assign redtemp3 = {3'b000, rcell[8], 1'b0, rcell[7], 1'b0, rcell[6]};

endmodule

// File: doc/ttt_turn_sequencer.md
Name: ttt_turn_sequencer

Overview:
- Game sequencer that owns the tic-tac-toe board registers for both players.
- Alternates turns between blue and red, validates and applies moves, and times out idle players.
- Evaluates win and draw one cycle after each accepted move.
- Drives the per-row board buses that the display and the winner-detection logic consume: cell c of a row sits at bit 2c, all other bits are 0, and a full row reads 8'b00010101.

Parameters:
- TURN_TIMEOUT, 0: cycles a player may hold the turn without a legal move before the turn passes; 0 disables the timeout.
- FIRST_PLAYER, 0: 0 = blue moves first, 1 = red moves first.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begin a new game; sampled only in IDLE or OVER.
- move_valid  input  1  move request strobe from the input front-end.
- move_row  input  2  row index 0..2 (3 is illegal).
- move_col  input  2  column index 0..2 (3 is illegal).
- move_ack  output  1  one-cycle pulse: move accepted.
- move_err  output  1  one-cycle pulse: move rejected.
- timeout  output  1  one-cycle pulse: turn forfeited by timeout.
- turn  output  2  2'b10 = blue to move, 2'b01 = red to move, 2'b00 = nobody.
- winner  output  2  2'b10 = blue, 2'b01 = red, 2'b11 = draw, 2'b00 = none.
- game_over  output  1  high while in OVER.
- btemp1, btemp2, btemp3  output  8  blue board rows 0..2.
- redtemp1, redtemp2, redtemp3  output  8  red board rows 0..2.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE.
  - All six row buses 8'h00; turn, winner, move_ack, move_err, timeout, game_over all 0.
  - Timeout counter 0.
  - Reset overrides everything, including mid-game and during CHECK.
- Odd bits (1,3,5,7) of every row bus are always 0.
- States: IDLE, BLUE, RED, CHECK, OVER.
- turn output: 2'b10 in BLUE, 2'b01 in RED, 2'b00 otherwise.
- All outputs are registered.
- IDLE / OVER:
  - On start = 1: clear all rows, clear winner, counter = 0, go to BLUE (FIRST_PLAYER = 0) or RED.
  - start is ignored in every other state.
- BLUE / RED, with move_valid = 1, the move is legal iff all of:
  - move_row < 3;
  - move_col < 3;
  - cell bit 2*move_col is 0 in both the blue and red row selected by move_row.
- Legal move, at the next edge:
  - set that bit in the current player's row;
  - move_ack = 1 for one cycle;
  - go to CHECK, recording which player moved.
- Illegal move:
  - move_err = 1 for one cycle;
  - no board change and no state change;
  - the counter keeps running.
- move_valid held high is evaluated on every cycle in a turn state; each cycle yields one ack or one err.
- Timeout (TURN_TIMEOUT > 0):
  - The counter increments each cycle in BLUE/RED and resets to 0 on entering either state.
  - When counter == TURN_TIMEOUT-1 and no legal move arrives that cycle: switch to the other player's state and pulse timeout for one cycle.
  - If a legal move and timeout expiry land on the same cycle, the move wins and no timeout pulse is issued.
  - An illegal move on the expiry cycle gives both move_err and timeout.
- CHECK (exactly one cycle):
  - Evaluate the 8 lines for the player who moved: 3 rows, 3 columns (same bit across all three rows), diagonal (bit0, bit2, bit4 in rows 0, 1, 2), anti-diagonal (bit4, bit2, bit0).
  - Win: go to OVER, winner = that player.
  - No win and all 9 cells occupied: go to OVER, winner = 2'b11.
  - Otherwise go to the opponent's state.
  - move_valid is ignored in CHECK: no ack, no err.
- Latency: move presented in cycle N; board and ack updated at edge N+1; winner, turn and game_over updated at edge N+2.
- OVER:
  - Board and winner hold.
  - move_valid is ignored and no timeout runs.

Test Plan:
- Blue-wins: start; blue (0,0), red (1,0), blue (0,1), red (1,1), blue (0,2) -> btemp1 = 8'h15, winner = 2'b10 and game_over = 1 two cycles after the last move, turn = 00.
- Red-wins diagonal: moves blue (0,1), red (0,0), blue (0,2), red (1,1), blue (1,0), red (2,2) -> redtemp1 = 8'h01, redtemp2 = 8'h04, redtemp3 = 8'h10, winner = 2'b01.
- Draw: a full 9-move sequence with no line -> winner = 2'b11; OR of blue and red rows = 8'h15 on each row.
- Illegal moves: red plays the occupied cell (0,0), then row = 3 -> move_err pulses twice, boards unchanged, turn stays 2'b01; a move during CHECK -> neither ack nor err.
- Timeout with TURN_TIMEOUT = 4: blue idle for 4 cycles -> timeout pulse, turn = 2'b01. Repeat with a legal move on the 4th cycle -> move_ack, no timeout.
- Reset mid-game after 3 moves (rst_n low 1 cycle) -> all rows 8'h00, winner 00, state IDLE; start afterwards begins a clean game.
